ov7670_capture: RTL and testbench

- Camera-side capture stage. Sits directly upstream of the video buffer that the QVGA display controller reads.
- Samples the OV7670 parallel bus (VSYNC/HREF/D[7:0], RGB565, QVGA mode) and assembles byte pairs into 16-bit pixels.
- Writes each pixel into the frame buffer at a linear address 0..H_PIXELS*V_LINES-1.
- Frame-synchronises on VSYNC and reports per-frame completion and error status.

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_pixel_pack.sv | 59 +++++
 rtl/ov7670_capture.sv | 143 ++++++++++++++
 tb/tb_ov7670_capture.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and QVGA geometry for the OV7670 capture path.
package cam_pkg;

  localparam int unsigned QVGA_W      = 320;
  localparam int unsigned QVGA_H      = 240;
  localparam int unsigned QVGA_PIXELS = 76800;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pixel565_t;

endpackage

// File: rtl/cam_pixel_pack.sv
// Registers the camera bus once, detects sync edges and pairs bytes into RGB565 pixels.
module cam_pixel_pack
  import cam_pkg::*;
(
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       capture,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       vsync_s1,
  output logic       pix_valid,
  output pixel565_t  pix_data,
  output logic       line_end,
  output logic       line_odd,
  output logic       frame_start,
  output logic       frame_end
);

  logic       vs1_q, vs2_q, hr1_q, hr2_q;
  logic [7:0] d1_q, hi_q;
  logic       phase_q;
  logic       byte_v;

  // A line byte is only valid outside vertical blanking.
  assign byte_v      = hr1_q & ~vs1_q;
  assign line_end    = ~hr1_q & hr2_q & ~vs2_q;
  assign line_odd    = phase_q;
  assign frame_start = ~vs1_q & vs2_q;
  assign frame_end   = vs1_q & ~vs2_q;
  assign vsync_s1    = vs1_q;
  assign pix_valid   = capture & byte_v & phase_q;
  assign pix_data    = {hi_q, d1_q};

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vs1_q   <= 1'b0;
      vs2_q   <= 1'b0;
      hr1_q   <= 1'b0;
      hr2_q   <= 1'b0;
      d1_q    <= '0;
      hi_q    <= '0;
      phase_q <= 1'b0;
    end else begin
      vs1_q <= cam_vsync;
      vs2_q <= vs1_q;
      hr1_q <= cam_href;
      hr2_q <= hr1_q;
      d1_q  <= cam_data;
      if (!capture || line_end) begin
        phase_q <= 1'b0;
      end else if (byte_v) begin
        if (!phase_q) hi_q <= d1_q;
        phase_q <= ~phase_q;
      end
    end
  end

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 QVGA capture: frame FSM, geometry counters, frame-buffer write port and status.
module ov7670_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_PIXELS = QVGA_W,
  parameter int unsigned V_LINES  = QVGA_H,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              cap_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [15:0]       w_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned PW = $clog2(H_PIXELS + 2);
  localparam int unsigned LW = $clog2(V_LINES + 2);
  localparam logic [PW-1:0] H_LAST = PW'(H_PIXELS);
  localparam logic [PW-1:0] H_SAT  = PW'(H_PIXELS + 1);
  localparam logic [LW-1:0] V_LAST = LW'(V_LINES);
  localparam logic [LW-1:0] V_SAT  = LW'(V_LINES + 1);

  cap_state_t        state_q, state_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]     line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [15:0]       w_data_q, w_data_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;

  logic      vsync_s1, pix_valid, line_end, line_odd, frame_start, frame_end;
  pixel565_t pix_data;

  cam_pixel_pack u_pack (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .capture     (state_q == CAPTURE),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .vsync_s1    (vsync_s1),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .line_end    (line_end),
    .line_odd    (line_odd),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    addr_d     = addr_q;
    err_d      = err_q;
    w_en_d     = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    done_d     = 1'b0;
    ferr_d     = ferr_q;
    case (state_q)
      IDLE: begin
        if (vsync_s1) state_d = SYNC;
      end
      SYNC: begin
        if (frame_start && cap_en) begin
          state_d    = CAPTURE;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          addr_d     = '0;
          err_d      = 1'b0;
        end
      end
      CAPTURE: begin
        if (pix_valid) begin
          if (pix_cnt_q < H_LAST && line_cnt_q < V_LAST) begin
            w_en_d   = 1'b1;
            w_addr_d = addr_q;
            w_data_d = pix_data;
            addr_d   = addr_q + ADDR_W'(1);
          end
          if (pix_cnt_q != H_SAT) pix_cnt_d = pix_cnt_q + PW'(1);
        end
        if (line_end) begin
          if (line_odd || pix_cnt_q != H_LAST) err_d = 1'b1;
          pix_cnt_d = '0;
          if (line_cnt_q != V_SAT) line_cnt_d = line_cnt_q + LW'(1);
        end
        // Uses the _d values so a line closing on the same cycle is counted first.
        if (frame_end) begin
          state_d = SYNC;
          done_d  = 1'b1;
          ferr_d  = (line_cnt_d != V_LAST) | err_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign w_en       = w_en_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign frame_done = done_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q == CAPTURE);

endmodule

// File: tb/tb_ov7670_capture.sv
// Self-checking bench for ov7670_capture on a reduced 8x6 geometry with random pixel data.
module tb_ov7670_capture;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 6;
  localparam int unsigned AW   = 6;
  localparam int unsigned NPIX = H * V;

  logic          pclk = 1'b0;
  logic          rst_n, cap_en, cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_data;
  logic          frame_done, frame_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] got_addr[$];
  logic [15:0]   got_data[$];
  int unsigned   exp_addr[$];
  logic [15:0]   exp_data[$];
  int            done_cnt, stray_wen, busy_cycles;
  logic          err_at_done;

  always #5 pclk = ~pclk;

  ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .cap_en     (cap_en),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(negedge pclk) begin
    if (w_en) begin
      got_addr.push_back(w_addr);
      got_data.push_back(w_data);
      if (!busy) stray_wen++;
    end
    if (busy) busy_cycles++;
    if (frame_done) begin
      done_cnt++;
      err_at_done = frame_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
    done_cnt    = 0;
    stray_wen   = 0;
    busy_cycles = 0;
    err_at_done = 1'bx;
  endtask

  task automatic frame_begin();
    @(negedge pclk);
    cam_vsync = 1'b1;
    repeat (4) @(negedge pclk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic frame_close();
    @(negedge pclk);
    cam_vsync = 1'b1;
    repeat (6) @(negedge pclk);
  endtask

  // Model: byte pair (2x, 2x+1) of line y lands at y*H+x when x<H and y<V.
  task automatic send_line(input int y, input int n, input bit ramp);
    logic [7:0] b, hi;
    hi = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      b        = ramp ? 8'(i) : 8'($urandom);
      cam_href = 1'b1;
      cam_data = b;
      if (i % 2 == 0) hi = b;
      else if (y < int'(V) && i / 2 < int'(H)) begin
        exp_addr.push_back(y * H + i / 2);
        exp_data.push_back({hi, b});
      end
    end
    @(negedge pclk);
    cam_href = 1'b0;
    cam_data = 8'($urandom);
    @(negedge pclk);
  endtask

  task automatic drive_frame(input int nlines, input int nbytes, input int odd_line, input bit ramp);
    frame_begin();
    for (int y = 0; y < nlines; y++) send_line(y, (y == odd_line) ? nbytes + 1 : nbytes, ramp);
    frame_close();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cap_en = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
    repeat (3) @(posedge pclk);
    #1;
    n_checks++;
    if ({w_en, w_addr, w_data, frame_done, frame_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected all zero", {w_en, w_addr, w_data, frame_done, frame_err, busy});
    end
    @(negedge pclk);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_nominal();
    int bad;
    cap_en = 1'b1;
    clear_obs();
    drive_frame(V, 2 * H, -1, 1'b1);
    n_checks++;
    if (got_addr.size() !== NPIX) begin
      n_fail++;
      $display("FAIL nominal_count: got %0d expected %0d", got_addr.size(), NPIX);
    end
    bad = 0;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] !== AW'(exp_addr[i]) || got_data[i] !== exp_data[i]) bad++;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL nominal_seq: got %0d bad writes expected 0", bad);
    end
    n_checks++;
    if (got_data.size() == 0 || got_data[0] !== 16'h0001) begin
      n_fail++;
      $display("FAIL nominal_pix0: got %h expected 0001", (got_data.size() > 0) ? got_data[0] : 16'hxxxx);
    end
    n_checks++;
    if (done_cnt != 1 || err_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_done: got done=%0d err=%b expected done=1 err=0", done_cnt, err_at_done);
    end
    n_checks++;
    if (stray_wen != 0) begin
      n_fail++;
      $display("FAIL nominal_wen_busy: got %0d w_en outside busy expected 0", stray_wen);
    end
  endtask

  task automatic test_latency();
    clear_obs();
    frame_begin();
    @(negedge pclk);
    cam_href = 1'b1;
    cam_data = 8'hAA;
    @(negedge pclk);
    cam_data = 8'h55;
    @(negedge pclk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    n_checks++;
    if (w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: got w_en=%b expected 0", w_en);
    end
    @(posedge pclk);
    #1;
    n_checks++;
    if (w_en !== 1'b1 || w_data !== 16'hAA55 || w_addr !== '0) begin
      n_fail++;
      $display("FAIL latency_write: got w_en=%b data=%h addr=%0d expected 1 AA55 0", w_en, w_data, w_addr);
    end
    repeat (3) @(negedge pclk);
    frame_close();
    n_checks++;
    if (done_cnt != 1 || err_at_done !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_short_frame: got done=%0d err=%b expected done=1 err=1", done_cnt, err_at_done);
    end
  endtask

  task automatic test_oversize();
    int bad;
    logic [AW-1:0] amax;
    clear_obs();
    drive_frame(V + 2, 2 * H + 6, -1, 1'b0);
    n_checks++;
    if (got_addr.size() !== NPIX) begin
      n_fail++;
      $display("FAIL oversize_count: got %0d expected %0d", got_addr.size(), NPIX);
    end
    bad  = 0;
    amax = '0;
    for (int i = 0; i < got_addr.size(); i++) begin
      if (got_addr[i] > amax) amax = got_addr[i];
      if (i < exp_addr.size() && (got_addr[i] !== AW'(exp_addr[i]) || got_data[i] !== exp_data[i])) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL oversize_seq: got %0d bad writes expected 0", bad);
    end
    n_checks++;
    if (amax !== AW'(NPIX - 1)) begin
      n_fail++;
      $display("FAIL oversize_maxaddr: got %0d expected %0d", amax, NPIX - 1);
    end
    n_checks++;
    if (done_cnt != 1 || err_at_done !== 1'b1) begin
      n_fail++;
      $display("FAIL oversize_err: got done=%0d err=%b expected done=1 err=1", done_cnt, err_at_done);
    end
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    frame_begin();
    for (int y = 0; y < 3; y++) send_line(y, 2 * H, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      cam_href = 1'b1;
      cam_data = 8'($urandom);
    end
    @(negedge pclk);
    rst_n    = 1'b0;
    cam_href = 1'b0;
    @(posedge pclk);
    #1;
    n_checks++;
    if ({w_en, w_addr, w_data, frame_done, frame_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b expected all zero", {w_en, w_addr, w_data, frame_done, frame_err, busy});
    end
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);
    n_checks++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL midreset_nodone: got %0d frame_done expected 0", done_cnt);
    end
    clear_obs();
    drive_frame(V, 2 * H, -1, 1'b0);
    n_checks++;
    if (got_addr.size() !== NPIX || got_addr[0] !== '0 || got_addr[NPIX-1] !== AW'(NPIX - 1)) begin
      n_fail++;
      $display("FAIL midreset_recover_addr: got count=%0d expected %0d from addr 0", got_addr.size(), NPIX);
    end
    n_checks++;
    if (got_data.size() == NPIX && got_data != exp_data) begin
      n_fail++;
      $display("FAIL midreset_recover_data: got data differing from model expected match");
    end
    n_checks++;
    if (done_cnt != 1 || err_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_recover_err: got done=%0d err=%b expected done=1 err=0", done_cnt, err_at_done);
    end
  endtask

  task automatic test_odd_byte();
    int bad;
    clear_obs();
    drive_frame(V, 2 * H, 3, 1'b0);
    bad = 0;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] !== AW'(exp_addr[i]) || got_data[i] !== exp_data[i]) bad++;
    n_checks++;
    if (got_addr.size() !== NPIX || bad != 0) begin
      n_fail++;
      $display("FAIL odd_seq: got count=%0d bad=%0d expected count=%0d bad=0", got_addr.size(), bad, NPIX);
    end
    n_checks++;
    if (err_at_done !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_err: got %b expected 1", err_at_done);
    end
    clear_obs();
    drive_frame(V, 2 * H, -1, 1'b0);
    n_checks++;
    if (got_addr.size() !== NPIX || err_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_clean_after: got count=%0d err=%b expected %0d err=0", got_addr.size(), err_at_done, NPIX);
    end
  endtask

  task automatic test_cap_disable();
    int bad;
    cap_en = 1'b0;
    clear_obs();
    drive_frame(V, 2 * H, -1, 1'b0);
    n_checks++;
    if (got_addr.size() != 0 || busy_cycles != 0 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL capdis_idle: got writes=%0d busy=%0d done=%0d expected 0 0 0", got_addr.size(), busy_cycles, done_cnt);
    end
    cap_en = 1'b1;
    clear_obs();
    drive_frame(V, 2 * H, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      if (got_addr[i] !== AW'(exp_addr[i]) || got_data[i] !== exp_data[i]) bad++;
    n_checks++;
    if (got_addr.size() !== NPIX || bad != 0 || got_addr[0] !== '0) begin
      n_fail++;
      $display("FAIL capdis_resume: got count=%0d bad=%0d expected count=%0d bad=0 from addr 0", got_addr.size(), bad, NPIX);
    end
    n_checks++;
    if (done_cnt != 1 || err_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL capdis_resume_done: got done=%0d err=%b expected done=1 err=0", done_cnt, err_at_done);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_latency();
    test_oversize();
    test_reset_midframe();
    test_odd_byte();
    test_cap_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
